// File: rtl/rtype_exec_ctrl_pkg.sv
// Shared encodings, ALU operation and FSM state types, and the R-type decoder
// for the register-memory execution controller.
package rtype_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_FAULT
  } state_t;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } decode_t;

  // Only the ten base R-type (funct7, funct3) pairs are legal; anything else
  // reports legal=0 and the op field is don't-care.
  function automatic decode_t decode(input logic [6:0] funct7, input logic [2:0] funct3);
    decode_t d;
    d.legal = 1'b0;
    d.op    = ALU_ADD;
    if (funct7 == F7_BASE) begin
      d.legal = 1'b1;
      case (funct3)
        F3_ADD_SUB: d.op = ALU_ADD;
        F3_SLL:     d.op = ALU_SLL;
        F3_SLT:     d.op = ALU_SLT;
        F3_SLTU:    d.op = ALU_SLTU;
        F3_XOR:     d.op = ALU_XOR;
        F3_SRL_SRA: d.op = ALU_SRL;
        F3_OR:      d.op = ALU_OR;
        default:    d.op = ALU_AND;
      endcase
    end else if (funct7 == F7_ALT) begin
      case (funct3)
        F3_ADD_SUB: begin
          d.legal = 1'b1;
          d.op    = ALU_SUB;
        end
        F3_SRL_SRA: begin
          d.legal = 1'b1;
          d.op    = ALU_SRA;
        end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_exec_ctrl_if.sv
// Instruction handshake, register-memory port and completion status bundle.
// instr_valid/instr_ready: a transfer happens on a rising edge where both are high;
// the source need only hold instr stable in that cycle, and instr_valid is ignored while busy.
interface rtype_exec_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    // Controller side: accepts instructions and initiates memory accesses.
    modport master (
        input  instr_valid, instr, rd_data1, rd_data2,
        output instr_ready, rd_en, rd_addr1, rd_addr2,
               wr_en, wr_addr, wr_data, done, err, result
    );

    // Environment side: instruction source plus the register memory.
    modport slave (
        output instr_valid, instr, rd_data1, rd_data2,
        input  instr_ready, rd_en, rd_addr1, rd_addr2,
               wr_en, wr_addr, wr_data, done, err, result
    );
endinterface

// File: rtl/rtype_exec_ctrl_alu.sv
// Combinational RV32I R-type ALU; shifts use only the low five bits of b.
module rtype_alu
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y
);
    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(DATA_W-1){1'b0}}, lt_signed};
            ALU_SLTU: y = {{(DATA_W-1){1'b0}}, lt_unsigned};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/rtype_exec_ctrl.sv
// Sequences one R-type instruction through read, execute and write-back
// against a 2R/1W register memory; illegal words are rejected with err.
module rtype_exec_ctrl
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    rtype_exec_ctrl_if.master   bus,
    output state_t              dbg_state
);
    state_t            state;
    state_t            state_nxt;
    decode_t           dec;
    logic              legal_in;
    logic              accept;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    alu_op_t           op_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_y;

    assign dec      = decode(bus.instr[31:25], bus.instr[14:12]);
    assign legal_in = (bus.instr[6:0] == OPC_RTYPE) && dec.legal;
    assign accept   = (state == ST_IDLE) && bus.instr_valid;

    rtype_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (bus.rd_data1),
        .b  (bus.rd_data2),
        .op (op_q),
        .y  (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            op_q     <= ALU_ADD;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rs1_q <= bus.instr[19:15];
                rs2_q <= bus.instr[24:20];
                rd_q  <= bus.instr[11:7];
                op_q  <= dec.op;
            end
            // Memory read data is only valid in EXEC, so capture the ALU there.
            if (state == ST_EXEC) begin
                result_q <= alu_y;
            end
        end
    end

    // The memory clears whatever wr_addr points at while wr_en is low, so the
    // write address and data idle at zero and only x0 is ever touched.
    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.rd_en       = 1'b0;
        bus.rd_addr1    = '0;
        bus.rd_addr2    = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = legal_in ? ST_READ : ST_FAULT;
                end
            end
            ST_READ: begin
                bus.rd_en    = 1'b1;
                bus.rd_addr1 = rs1_q;
                bus.rd_addr2 = rs2_q;
                state_nxt    = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                bus.done = 1'b1;
                if (rd_q != '0) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = rd_q;
                    bus.wr_data = result_q;
                end
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                bus.done  = 1'b1;
                bus.err   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.result = result_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Directed bench for rtype_exec_ctrl: a behavioural register memory, a driver
// that queues hand-computed completions, and a monitor that checks each done.
module tb_rtype_exec_ctrl;
  import rtype_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    logic              err;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] res;
    int                cyc;
    string             name;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     done_cnt = 0;
  exp_t   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtype_exec_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rtype_exec_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- register memory model ----------------
  logic [DATA_W-1:0] mem [32];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data1 <= mem[bus.rd_addr1];
      bus.rd_data2 <= mem[bus.rd_addr2];
    end
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    else mem[bus.wr_addr] <= '0;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OPC_RTYPE};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input int addr, input logic [DATA_W-1:0] data);
    pl_en   = 1'b1;
    pl_addr = ADDR_W'(addr);
    pl_data = data;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the accept cycle.
  task automatic offer(input logic [31:0] w, output int t);
    int waited;
    waited = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    t = cyc;
    if (!bus.instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got instr_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue(input string name, input logic [31:0] w, input logic legal,
                       input logic [DATA_W-1:0] res, input bit hold, output int t);
    exp_t e;
    offer(w, t);
    e.err  = !legal;
    e.we   = legal && (w[11:7] != 5'd0);
    e.wa   = e.we ? w[11:7] : '0;
    e.wd   = e.we ? res : '0;
    e.res  = res;
    e.cyc  = t + (legal ? 3 : 1);
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    chk({name, ".rd_en"}, 32'(bus.rd_en), 32'(legal));
    if (legal) begin
      chk({name, ".rd_addr1"}, 32'(bus.rd_addr1), 32'(w[19:15]));
      chk({name, ".rd_addr2"}, 32'(bus.rd_addr2), 32'(w[24:20]));
    end
    if (!hold) begin
      bus.instr_valid = 1'b0;
      bus.instr       = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!bus.wr_en) begin
      chk("idle_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("idle_wr_data", bus.wr_data, 32'd0);
    end
    if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, ".cycle"},   32'(cyc),         32'(e.cyc));
        chk({e.name, ".err"},     32'(bus.err),     32'(e.err));
        chk({e.name, ".wr_en"},   32'(bus.wr_en),   32'(e.we));
        chk({e.name, ".wr_addr"}, 32'(bus.wr_addr), 32'(e.wa));
        chk({e.name, ".wr_data"}, bus.wr_data,      e.wd);
        chk({e.name, ".result"},  bus.result,       e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t, t0, t1, t2, d0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (2) @(negedge clk);
    chk("rst.instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst.rd_en",       32'(bus.rd_en),       32'd0);
    chk("rst.wr_en",       32'(bus.wr_en),       32'd0);
    chk("rst.done",        32'(bus.done),        32'd0);
    chk("rst.err",         32'(bus.err),         32'd0);
    chk("rst.result",      bus.result,           32'd0);
    rst = 1'b0;
    @(negedge clk);

    load(1, 32'd5); load(2, 32'd3);
    issue("add_x3", 32'h002081B3, 1'b1, 32'd8, 1'b0, t);
    drain();
    chk("mem_x3", mem[3], 32'd8);

    load(1, 32'd3); load(2, 32'd5);
    issue("sub_x4", mk(F7_ALT,  F3_ADD_SUB, 5'd4, 5'd1, 5'd2), 1'b1, 32'hFFFF_FFFE, 1'b0, t);
    issue("slt_x5", mk(F7_BASE, F3_SLT,     5'd5, 5'd1, 5'd2), 1'b1, 32'd1, 1'b0, t);
    drain();
    chk("mem_x4", mem[4], 32'hFFFF_FFFE);
    chk("mem_x5", mem[5], 32'd1);

    load(1, 32'hFFFF_FFFF); load(2, 32'd1);
    issue("sltu_x6", mk(F7_BASE, F3_SLTU,    5'd6,  5'd1, 5'd2), 1'b1, 32'd0, 1'b0, t);
    issue("slt_x7",  mk(F7_BASE, F3_SLT,     5'd7,  5'd1, 5'd2), 1'b1, 32'd1, 1'b0, t);
    issue("add_x11", mk(F7_BASE, F3_ADD_SUB, 5'd11, 5'd1, 5'd2), 1'b1, 32'd0, 1'b0, t);
    drain();

    load(1, 32'h8000_0000); load(2, 32'h24);
    issue("sra_x8",  mk(F7_ALT,  F3_SRL_SRA, 5'd8,  5'd1, 5'd2), 1'b1, 32'hF800_0000, 1'b0, t);
    issue("srl_x9",  mk(F7_BASE, F3_SRL_SRA, 5'd9,  5'd1, 5'd2), 1'b1, 32'h0800_0000, 1'b0, t);
    issue("sll_x10", mk(F7_BASE, F3_SLL,     5'd10, 5'd1, 5'd2), 1'b1, 32'h0000_0000, 1'b0, t);
    drain();
    chk("mem_x8", mem[8], 32'hF800_0000);

    load(1, 32'h0F0F_00FF); load(2, 32'h00FF_0F0F);
    issue("xor_x12", mk(F7_BASE, F3_XOR, 5'd12, 5'd1, 5'd2), 1'b1, 32'h0FF0_0FF0, 1'b0, t);
    issue("or_x13",  mk(F7_BASE, F3_OR,  5'd13, 5'd1, 5'd2), 1'b1, 32'h0FFF_0FFF, 1'b0, t);
    issue("and_x14", mk(F7_BASE, F3_AND, 5'd14, 5'd1, 5'd2), 1'b1, 32'h000F_000F, 1'b0, t);
    drain();
    chk("mem_x13", mem[13], 32'h0FFF_0FFF);

    load(1, 32'd7); load(2, 32'd9);
    issue("add_x0", mk(F7_BASE, F3_ADD_SUB, 5'd0, 5'd1, 5'd2), 1'b1, 32'd16, 1'b0, t);
    drain();
    chk("mem_x0", mem[0], 32'd0);

    load(15, 32'h0000_ABCD);
    issue("opimm_illegal", 32'h0000_0013, 1'b0, 32'd16, 1'b0, t);
    issue("alt_and_illegal", mk(F7_ALT, F3_AND, 5'd15, 5'd1, 5'd2), 1'b0, 32'd16, 1'b0, t);
    drain();
    chk("illegal.result_held", bus.result, 32'd16);
    chk("illegal.mem_x15", mem[15], 32'h0000_ABCD);

    // Reset in the WRITE cycle of ADD x6,x1,x2.
    load(6, 32'h0000_1234); load(1, 32'd5); load(2, 32'd3);
    d0 = done_cnt;
    offer(mk(F7_BASE, F3_ADD_SUB, 5'd6, 5'd1, 5'd2), t);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstw.pre_wr_en", 32'(bus.wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw.wr_en", 32'(bus.wr_en), 32'd0);
    chk("rstw.rd_en", 32'(bus.rd_en), 32'd0);
    chk("rstw.done",  32'(bus.done),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("rstw.result", bus.result, 32'd0);
    @(negedge clk);
    chk("rstw.mem_x6", mem[6], 32'h0000_1234);
    chk("rstw.no_done", 32'(done_cnt - d0), 32'd0);

    // instr_valid held high across three back-to-back ADDs.
    d0 = done_cnt;
    issue("b2b_0", mk(F7_BASE, F3_ADD_SUB, 5'd16, 5'd1, 5'd2), 1'b1, 32'd8, 1'b1, t0);
    issue("b2b_1", mk(F7_BASE, F3_ADD_SUB, 5'd17, 5'd1, 5'd2), 1'b1, 32'd8, 1'b1, t1);
    issue("b2b_2", mk(F7_BASE, F3_ADD_SUB, 5'd18, 5'd1, 5'd2), 1'b1, 32'd8, 1'b0, t2);
    chk("b2b.gap01", 32'(t1 - t0), 32'd4);
    chk("b2b.gap12", 32'(t2 - t1), 32'd4);
    drain();
    repeat (4) @(negedge clk);
    chk("b2b.done_count", 32'(done_cnt - d0), 32'd3);
    chk("b2b.mem_x18", mem[18], 32'd8);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_exec_ctrl.md
# rtype_exec_ctrl

Sequencing initiator for the 32-entry register memory (2 registered read ports, 1 write port). Accepts one RV32I R-type instruction per handshake, decodes it, and reads rs1/rs2 from the memory. It then executes the ALU operation and writes the result back to rd. It sits between the instruction source (fetch/testbench) and the register memory, and drives the memory's `rd_en`/`wr_en` side.

## Interface
- `DATA_W`, 32, register/data width
- `ADDR_W`, 5, register index width (32 entries)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  instruction offered
- `instr`  in  32  RV32I instruction word
- `instr_ready`  out  1  high only in IDLE
- `rd_en`  out  1  memory read enable
- `rd_addr1`  out  ADDR_W  rs1 index
- `rd_addr2`  out  ADDR_W  rs2 index
- `rd_data1`  in  DATA_W  memory read data 1, valid cycle after `rd_en`
- `rd_data2`  in  DATA_W  memory read data 2, valid cycle after `rd_en`
- `wr_en`  out  1  memory write enable
- `wr_addr`  out  ADDR_W  rd index
- `wr_data`  out  DATA_W  write-back value
- `done`  out  1  one-cycle pulse per completed or rejected instruction
- `err`  out  1  qualifies `done`: instruction was illegal
- `result`  out  DATA_W  last ALU result, held until next EXEC

## Operation
- States: IDLE, READ, EXEC, WRITE, FAULT.
- IDLE: `instr_ready`=1. On `instr_valid`, latch `instr`.
  - If opcode is 7'b0110011 and the funct3/funct7 pair is legal, go to READ.
  - Otherwise go to FAULT.
- READ: `rd_en`=1, `rd_addr1`=instr[19:15], `rd_addr2`=instr[24:20]; go to EXEC.
- EXEC: `rd_data1`/`rd_data2` are valid. Compute the ALU result, register it into `result`, then go to WRITE.
- WRITE: `wr_en`=1 unless rd (instr[11:7]) is 0. `wr_addr`=rd, `wr_data`=`result`, `done`=1, `err`=0. Go to IDLE.
- FAULT: no memory access; `done`=1, `err`=1; `result` unchanged. Go to IDLE.
- Legal ops (funct7, funct3):
  - ADD (0000000, 000); SUB (0100000, 000)
  - SLL (0000000, 001); SLT (0000000, 010); SLTU (0000000, 011)
  - XOR (0000000, 100); SRL (0000000, 101); SRA (0100000, 101)
  - OR (0000000, 110); AND (0000000, 111)
  - Any other pair → FAULT.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W.
  - Shift amount is rs2[4:0] only.
  - SLT is signed and SLTU unsigned; both produce 0 or 1 zero-extended.
  - SRA sign-fills.
- Write-address discipline: the memory clears the addressed entry whenever `wr_en` is low. `wr_addr` and `wr_data` are therefore driven to 0 in every cycle where `wr_en`=0, so only x0 is ever touched.
- rd = 0: result computed and `done` pulses, but `wr_en` stays 0 (x0 never written).
- `rd_en`, `rd_addr1` and `rd_addr2` are 0 outside READ.
- Reset values: state IDLE. All outputs 0 except `instr_ready`=1.
- Reset mid-operation: asynchronous reset aborts immediately. `wr_en`/`rd_en` drop in the same cycle, no `done` is emitted, and the latched instruction is discarded.

## Timing
- Accept at cycle T (`instr_valid` & `instr_ready`).
  - T+1: `rd_en`.
  - T+2: EXEC, operands sampled.
  - T+3: `wr_en` + `done`; memory updated at the end of T+3.
  - T+4: IDLE, `instr_ready`=1.
- Throughput: 1 instruction per 4 cycles. Back-to-back acceptance at T+4 is legal.
- Illegal instruction: `done`/`err` at T+1; IDLE again at T+2.
- Read-after-write: the next instruction's READ (T+5 or later) follows the T+3 write, so no hazard logic is needed.
- `instr_valid` is ignored outside IDLE. The source holds `instr` stable only during the accept cycle.

## Structure
- Package `rtype_pkg`:
  - `OPC_RTYPE` constant
  - funct3/funct7 encodings
  - `alu_op_t` enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND)
  - `state_t` enum
  - decode function mapping (funct7, funct3) → {legal, `alu_op_t`}
- Sub-module `rtype_alu`: purely combinational, inputs `a`, `b`, `op`, output `y`. Instantiated once, with its output registered in EXEC.
- Top-level holds the FSM, instruction latch and `result` register.

## Test plan
- Preload x1=5, x2=3; ADD x3,x1,x2 (0x002081B3) → `rd_en` at T+1 with addrs 1/2, `wr_en` at T+3 with `wr_addr`=3, `wr_data`=8, `done`=1, `err`=0.
- x1=3, x2=5: SUB x4,x1,x2 → 0xFFFFFFFE; SLT x5 → 1; SLTU with x1=0xFFFFFFFF, x2=1 → 0; SRA of 0x80000000 by x2=0x24 (amount 4) → 0xF8000000.
- ADD x0,x1,x2 → `done` at T+3, `wr_en` stays 0, `wr_addr`/`wr_data`=0 every cycle, x0 reads back 0.
- Illegal word 0x00000013 (OP-IMM) and funct7=0100000 with funct3=111 → `done`=`err`=1 at T+1, `rd_en`/`wr_en` never asserted, `result` unchanged.
- Assert `rst` in the WRITE cycle of an ADD → `wr_en` low in the same cycle, no `done`, target register keeps its old value, and after release `instr_ready`=1.
- Hold `instr_valid` continuously for 3 ADDs → accepts at T, T+4, T+8; exactly 3 `done` pulses; `instr_ready` low during busy cycles.
